// File: rtl/xbar_mem_slave.sv
// xbar_mem_slave: word-addressed memory slave on a crossbar output with programmable wait states
module xbar_mem_slave #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [65:0] in_m,
  output logic [32:0] out_s,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WCNT_INIT = 4'(WAIT_CYC == 0 ? 0 : WAIT_CYC - 1);
  state_t state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic cmd_q, cmd_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] mem [2**ADDR_W];
  logic commit;
  logic unused;
  assign unused = ^{in_m[63:ADDR_W+34], in_m[33:32]};
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && in_m[65]) begin
      cmd_d   = in_m[64];
      idx_d   = in_m[ADDR_W+33:34];
      wdata_d = in_m[31:0];
      wcnt_d  = WCNT_INIT;
      state_d = WAIT_CYC == 0 ? RESP : WAIT;
    end else if (state_q == WAIT) begin
      wcnt_d  = wcnt_q == 4'd0 ? 4'd0 : wcnt_q - 4'd1;
      state_d = wcnt_q == 4'd0 ? RESP : WAIT;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    // the edge entering RESP both commits a write and samples read data
    commit  = state_d == RESP;
    rdata_d = commit ? (cmd_d ? 32'd0 : mem[idx_d]) : rdata_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge clk)
    if (reset && commit && cmd_d) mem[idx_d] <= wdata_d;
  assign out_s = state_q == RESP ? {1'b1, rdata_q} : 33'd0;
  assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_xbar_mem_slave.sv
// tb_xbar_mem_slave: directed vectors for the memory slave in WAIT_CYC=2, 0 and 4 builds
module tb_xbar_mem_slave;
  localparam int W = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [65:0] in_m = '0, in_m0 = '0, in_m4 = '0;
  logic [32:0] out_s, out_s0, out_s4;
  logic busy, busy0, busy4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  xbar_mem_slave #(.ADDR_W(8), .WAIT_CYC(W)) dut (.clk(clk), .reset(reset), .in_m(in_m), .out_s(out_s), .busy(busy));
  xbar_mem_slave #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (.clk(clk), .reset(reset), .in_m(in_m0), .out_s(out_s0), .busy(busy0));
  xbar_mem_slave #(.ADDR_W(8), .WAIT_CYC(4)) dut4 (.clk(clk), .reset(reset), .in_m(in_m4), .out_s(out_s4), .busy(busy4));
  typedef struct {
    string       name;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic txn(input string nm, input logic cmd, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
    int n = 0;
    in_m = {1'b1, cmd, addr, wd};
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (!out_s[32]) chk({nm, " busy_wait"}, 33'(busy), 33'd1);
    end while (!out_s[32] && n < 20);
    chk({nm, " latency"}, 33'(n), 33'(W + 1));
    chk({nm, " resp"}, out_s, {1'b1, exp});
    chk({nm, " busy_ack"}, 33'(busy), 33'd1);
    in_m = '0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " ack_once"}, out_s, 33'd0);
    chk({nm, " idle"}, 33'(busy), 33'd0);
  endtask
  initial begin
    int t1, t2, cnt;
    vecs[0] = '{"wr5", 1'b1, 32'h0000_0014, 32'h5555_5555, 32'h0};
    vecs[1] = '{"wr10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{"rd10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF};
    vecs[3] = '{"wr_alias", 1'b1, 32'h8000_0404, 32'h1234_5678, 32'h0};
    vecs[4] = '{"rd404", 1'b0, 32'h0000_0404, 32'h0, 32'h1234_5678};
    vecs[5] = '{"rd406", 1'b0, 32'h0000_0406, 32'h0, 32'h1234_5678};
    vecs[6] = '{"rd004", 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[7] = '{"wr255", 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{"rd255", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D};
    vecs[9] = '{"rd5", 1'b0, 32'h0000_0014, 32'h0, 32'h5555_5555};
    in_m = {1'b1, 1'b1, 32'h0000_0014, 32'h5555_5555};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", out_s, 33'd0);
      chk("rst_busy", 33'(busy), 33'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) txn(vecs[i].name, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    // reset during WAIT discards the pending write
    in_m = {1'b1, 1'b1, 32'h0000_0014, 32'hAAAA_AAAA};
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 33'(busy), 33'd1);
    reset = 1'b0;
    #1;
    chk("abort_out", out_s, 33'd0);
    chk("abort_idle", 33'(busy), 33'd0);
    in_m = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    txn("abort_rd5", 1'b0, 32'h0000_0014, 32'h0, 32'h5555_5555);
    // back-to-back reads with req held through ack
    in_m = {1'b1, 1'b0, 32'h0000_0010, 32'h0};
    t1 = 0; t2 = 0; cnt = 0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_s[32]) begin
        cnt++;
        if (t1 == 0) t1 = n; else t2 = n;
        chk("b2b_data", out_s, {1'b1, 32'hDEAD_BEEF});
      end
    end
    in_m = '0;
    chk("b2b_count", 33'(cnt), 33'd2);
    chk("b2b_first", 33'(t1), 33'(W + 1));
    chk("b2b_gap", 33'(t2 - t1), 33'(W + 2));
    repeat (4) @(negedge clk);
    chk("b2b_drain", 33'(busy), 33'd0);
    // zero-wait build: ack in the cycle after capture
    in_m0 = {1'b1, 1'b1, 32'h0000_000C, 32'h0BAD_F00D};
    @(posedge clk);
    @(negedge clk);
    chk("w0_wr", out_s0, {1'b1, 32'h0});
    chk("w0_busy", 33'(busy0), 33'd1);
    in_m0 = '0;
    @(posedge clk);
    @(negedge clk);
    chk("w0_ack_once", out_s0, 33'd0);
    in_m0 = {1'b1, 1'b0, 32'h0000_000C, 32'h0};
    @(posedge clk);
    @(negedge clk);
    chk("w0_rd", out_s0, {1'b1, 32'h0BAD_F00D});
    in_m0 = '0;
    // four-wait build: req dropped mid-WAIT still completes the write
    in_m4 = {1'b1, 1'b1, 32'h0000_0008, 32'h0000_0077};
    t1 = 0; cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) in_m4 = '0;
      if (out_s4[32]) begin
        cnt++;
        t1 = n;
      end
    end
    chk("w4_drop_count", 33'(cnt), 33'd1);
    chk("w4_drop_time", 33'(t1), 33'd5);
    in_m4 = {1'b1, 1'b0, 32'h0000_0008, 32'h0};
    cnt = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end while (!out_s4[32] && cnt < 20);
    chk("w4_rd_lat", 33'(cnt), 33'd5);
    chk("w4_rd", out_s4, {1'b1, 32'h0000_0077});
    in_m4 = '0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xbar_mem_slave.md
Name: xbar_mem_slave

Overview:
- Single-port word-addressed memory slave on one crossbar slave output.
- Consumes the 66-bit master bundle {req, cmd, addr[31:0], wdata[31:0]} that the crossbar drives on out0_m/out1_m.
- Returns the 33-bit slave bundle {ack, rdata[31:0]} on the matching crossbar slave input (in0_s/in1_s).
- Inserts a programmable number of wait states, so the crossbar arbiter's hold-until-ack behaviour is exercised.

Parameters:
- ADDR_W, 8: number of word-address bits used; memory depth = 2**ADDR_W words of 32 bits.
- WAIT_CYC, 2: wait-state count between request capture and ack (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
- in_m  input  66  master bundle: [65]=req, [64]=cmd (1=write, 0=read), [63:32]=addr, [31:0]=wdata.
- out_s  output  33  slave bundle: [32]=ack, [31:0]=rdata.
- busy  output  1  high from request capture through the ack cycle.

Behaviour:
- Word index is addr[ADDR_W+1:2]. addr[1:0] and addr[31:ADDR_W+2] are ignored, so aliasing is allowed. addr[31] is the crossbar routing bit and is don't-care here.
- FSM states: IDLE, WAIT, RESP. A 4-bit wait counter wcnt is used.
- IDLE: at a clock edge with req=1, capture cmd, word index and wdata into registers and set busy=1.
  - If WAIT_CYC=0, go to RESP.
  - Otherwise load wcnt=WAIT_CYC-1 and go to WAIT.
- WAIT: decrement wcnt each cycle. When wcnt=0, go to RESP.
- RESP (exactly one cycle): ack=1. Next state is IDLE.
  - Write: mem[idx] <= wdata on the edge entering RESP. rdata=0 during RESP.
  - Read: rdata = mem[idx], registered on the edge entering RESP. It is valid only while ack=1.
- Latency: ack is high in cycle k+WAIT_CYC+1 when req is first sampled at edge k. With WAIT_CYC=2, ack comes 3 cycles after capture.
- out_s = 33'd0 whenever state != RESP. ack is never high for two consecutive cycles.
- Handshake: the master holds the bundle stable with req=1 until it samples ack=1, and drops req on that same edge.
  - If req is still 1 in IDLE after RESP, it is treated as a new transaction. Back-to-back transactions therefore have one idle cycle between acks.
- req dropping during WAIT does not abort the transaction: it completes, ack still pulses and the write still commits.
- Changes to in_m after capture are ignored until the block returns to IDLE.
- Read-after-write to the same index: the read returns the newly written data.
- Reset (reset=0, any time):
  - State=IDLE, wcnt=0, captured registers=0, out_s=0, busy=0.
  - A write that has not yet reached RESP is not committed.
  - Memory contents are not reset; they are undefined until first written.
- Reset release: the first capture can occur at the first rising edge with reset=1 and req=1.

Test Plan:
- Reset: hold reset=0 with req=1 → out_s=0 and busy=0 throughout. After release, the first capture happens at the first edge.
- Write then read, WAIT_CYC=2: write addr=0x0000_0010, wdata=0xDEAD_BEEF → ack at capture+3 with rdata=0. Then read addr=0x0000_0010 → ack at capture+3 with rdata=0xDEAD_BEEF.
- Aliasing, ADDR_W=8: write 0x1234_5678 to addr=0x8000_0404 → a read of addr=0x0000_0404 returns 0x1234_5678. A read of addr=0x0000_0406 also returns it.
- Back-to-back with req held high through ack: two reads → acks are separated by exactly WAIT_CYC+2 cycles, and each ack lasts exactly 1 cycle.
- Abort: assert reset during WAIT of a write of 0xAAAA_AAAA to index 5 that previously held 0x5555_5555 → after reset, a read of index 5 returns 0x5555_5555.
- WAIT_CYC=0 build: a read request gives ack in the cycle after capture. Dropping req mid-WAIT (WAIT_CYC=4 build) still yields a single ack at capture+5.
